// File: rtl/norm_result_packer.sv
// norm_result_packer
//
// Sits behind the four-lane vector normaliser. When all four lane valids are
// high together, each quotient is saturated down to OUT_WIDTH bits and the
// resulting vector is written into a small FIFO that holds whole vectors. The
// FIFO is drained as a serial element stream, one element per valid/ready
// beat, lane A first. Vectors that arrive while the FIFO is full are counted
// as drops. A cycle where some but not all lane valids are high is recorded as
// a sticky misalignment error.
//
// Ports:
//   clk             - single clock, rising edge
//   rst             - asynchronous reset, active low
//   i_valid_A..D    - per-lane quotient valid
//   i_q_A..D        - per-lane quotient, QW bits, FRAC_BITS fractional bits
//   o_valid         - output element valid
//   i_ready         - downstream ready
//   o_data          - current element (saturated, OUT_WIDTH bits)
//   o_idx           - lane index of o_data (0=A .. 3=D)
//   o_last          - high on the lane-D element of a vector
//   o_count         - number of whole vectors held in the FIFO
//   o_drop_cnt      - saturating count of vectors lost to a full FIFO
//   o_err_misalign  - sticky lane-misalignment flag

module norm_result_packer #(
    parameter int DATAWIDTH = 8,
    parameter int FRAC_BITS = 8,
    parameter int OUT_WIDTH = FRAC_BITS + 1,
    parameter int DEPTH     = 4,
    localparam int QW       = 2 * DATAWIDTH + 2,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid_A,
    input  logic                 i_valid_B,
    input  logic                 i_valid_C,
    input  logic                 i_valid_D,
    input  logic [QW-1:0]        i_q_A,
    input  logic [QW-1:0]        i_q_B,
    input  logic [QW-1:0]        i_q_C,
    input  logic [QW-1:0]        i_q_D,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic [1:0]           o_idx,
    output logic                 o_last,
    output logic [CW-1:0]        o_count,
    output logic [15:0]          o_drop_cnt,
    output logic                 o_err_misalign
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t state;

    // One FIFO entry is a whole vector: four saturated elements.
    logic [OUT_WIDTH-1:0] mem [DEPTH][4];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          all_valid;
    logic          any_valid;
    logic          handshake;
    logic          pop;
    logic          push;
    logic          drop;
    logic [CW-1:0] count_next;

    // Anything at or above 2^OUT_WIDTH clamps to all ones; otherwise the low
    // bits are kept unchanged (same binary point, no rounding).
    function automatic logic [OUT_WIDTH-1:0] sat(input logic [QW-1:0] q);
        if (|q[QW-1:OUT_WIDTH]) begin
            return '1;
        end
        return q[OUT_WIDTH-1:0];
    endfunction

    assign all_valid = i_valid_A & i_valid_B & i_valid_C & i_valid_D;
    assign any_valid = i_valid_A | i_valid_B | i_valid_C | i_valid_D;
    assign handshake = o_valid & i_ready;

    // The head vector leaves the FIFO when its lane-D element is accepted.
    assign pop  = handshake & (o_idx == 2'd3);

    // A full FIFO can still take a vector if the head is leaving this cycle.
    assign push = all_valid & ((o_count < CW'(DEPTH)) | pop);
    assign drop = all_valid & ~push;

    // Occupancy after this edge; the serializer uses it to decide whether to
    // keep streaming without a bubble.
    always_comb begin
        count_next = o_count;
        if (push && !pop) begin
            count_next = o_count + 1'b1;
        end else if (pop && !push) begin
            count_next = o_count - 1'b1;
        end
    end

    // Vector storage. The contents need no reset: o_data is masked while
    // o_valid is low and o_count decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr][0] <= sat(i_q_A);
            mem[wr_ptr][1] <= sat(i_q_B);
            mem[wr_ptr][2] <= sat(i_q_C);
            mem[wr_ptr][3] <= sat(i_q_D);
        end
    end

    // FIFO bookkeeping and status. Pointers wrap naturally because DEPTH is a
    // power of two; full versus empty is read from o_count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            o_count        <= '0;
            o_drop_cnt     <= '0;
            o_err_misalign <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            o_count <= count_next;
            if (drop && (o_drop_cnt != 16'hFFFF)) begin
                o_drop_cnt <= o_drop_cnt + 1'b1;
            end
            if (any_valid && !all_valid) begin
                o_err_misalign <= 1'b1;
            end
        end
    end

    // Serializer. IDLE waits until the registered count shows a vector, which
    // gives one cycle from capture to the first o_valid. SEND walks the four
    // lanes of the head vector and only falls back to IDLE when the FIFO will
    // be empty after the final beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_idx   <= 2'd0;
            o_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (o_count != '0) begin
                        state   <= SEND;
                        o_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (o_idx == 2'd3) begin
                            o_idx  <= 2'd0;
                            o_last <= 1'b0;
                            if (count_next == '0) begin
                                state   <= IDLE;
                                o_valid <= 1'b0;
                            end
                        end else begin
                            o_idx  <= o_idx + 1'b1;
                            o_last <= (o_idx == 2'd2);
                        end
                    end
                end
            endcase
        end
    end

    assign o_data = o_valid ? mem[rd_ptr][o_idx] : '0;

endmodule

// File: tb/tb_norm_result_packer.sv
// Testbench for norm_result_packer: directed scenarios with literal
// expectations plus a randomized run, all compared against a queue-based
// reference model every cycle.

module tb_norm_result_packer;

    localparam int OW    = 9;
    localparam int QW    = 18;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_valid_A = 1'b0;
    logic          i_valid_B = 1'b0;
    logic          i_valid_C = 1'b0;
    logic          i_valid_D = 1'b0;
    logic [QW-1:0] i_q_A = '0;
    logic [QW-1:0] i_q_B = '0;
    logic [QW-1:0] i_q_C = '0;
    logic [QW-1:0] i_q_D = '0;
    logic          i_ready = 1'b0;
    logic          o_valid;
    logic [OW-1:0] o_data;
    logic [1:0]    o_idx;
    logic          o_last;
    logic [CW-1:0] o_count;
    logic [15:0]   o_drop_cnt;
    logic          o_err_misalign;

    int checks = 0;
    int errors = 0;

    norm_result_packer dut (
        .clk            (clk),
        .rst            (rst),
        .i_valid_A      (i_valid_A),
        .i_valid_B      (i_valid_B),
        .i_valid_C      (i_valid_C),
        .i_valid_D      (i_valid_D),
        .i_q_A          (i_q_A),
        .i_q_B          (i_q_B),
        .i_q_C          (i_q_C),
        .i_q_D          (i_q_D),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_data         (o_data),
        .o_idx          (o_idx),
        .o_last         (o_last),
        .o_count        (o_count),
        .o_drop_cnt     (o_drop_cnt),
        .o_err_misalign (o_err_misalign)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of whole vectors, the lane being offered,
    // whether the stream is currently offering, and the status counters.
    int modelQ [$][4];
    int modelIdx   = 0;
    bit modelValid = 1'b0;
    int modelDrop  = 0;
    bit modelErr   = 1'b0;

    int oldSize;
    bit hs;
    bit popNow;
    bit allV;
    bit anyV;
    int newVec [4];

    function automatic int satModel(input int q);
        return (q >= (1 << OW)) ? (1 << OW) - 1 : q;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] mask, input int a, input int b, input int c, input int d);
        i_valid_A = mask[0];
        i_valid_B = mask[1];
        i_valid_C = mask[2];
        i_valid_D = mask[3];
        i_q_A = QW'(a);
        i_q_B = QW'(b);
        i_q_C = QW'(c);
        i_q_D = QW'(d);
    endtask

    // Model update on each clock edge from the inputs alone.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            modelQ.delete();
            modelIdx   = 0;
            modelValid = 1'b0;
            modelDrop  = 0;
            modelErr   = 1'b0;
        end else begin
            oldSize = modelQ.size();
            hs      = modelValid && i_ready;
            popNow  = hs && (modelIdx == 3);
            allV    = i_valid_A && i_valid_B && i_valid_C && i_valid_D;
            anyV    = i_valid_A || i_valid_B || i_valid_C || i_valid_D;
            if (anyV && !allV) modelErr = 1'b1;
            if (popNow) modelQ.pop_front();
            if (allV) begin
                if (oldSize < DEPTH || popNow) begin
                    newVec[0] = satModel(int'(i_q_A));
                    newVec[1] = satModel(int'(i_q_B));
                    newVec[2] = satModel(int'(i_q_C));
                    newVec[3] = satModel(int'(i_q_D));
                    modelQ.push_back(newVec);
                end else if (modelDrop < 65535) begin
                    modelDrop++;
                end
            end
            if (hs) modelIdx = (modelIdx + 1) % 4;
            if (!modelValid) modelValid = (oldSize != 0);
            else if (popNow) modelValid = (modelQ.size() != 0);
        end
    end

    // Every-cycle comparison of the DUT against the model, away from the edge.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("model_valid", o_valid, modelValid);
            checkOutput("model_count", o_count, modelQ.size());
            checkOutput("model_drop", o_drop_cnt, modelDrop);
            checkOutput("model_err", o_err_misalign, modelErr);
            checkOutput("model_idx", o_idx, modelIdx);
            checkOutput("model_last", o_last, modelIdx == 3);
            if (modelValid && modelQ.size() != 0) begin
                checkOutput("model_data", o_data, modelQ[0][modelIdx]);
            end
        end
    end

    task automatic waitDrain(input int budget);
        int n = 0;
        i_ready = 1'b1;
        while ((modelQ.size() != 0 || modelValid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_within_budget", n < budget, 1);
    endtask

    function automatic int randQ();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, (1 << QW) - 1));
            1:       return int'($urandom_range(500, 530));
            default: return int'($urandom_range(0, 511));
        endcase
    endfunction

    task automatic testSingle();
        i_ready = 1'b1;
        @(negedge clk); applyStimulus(4'hF, 256, 0, 0, 0);
        @(negedge clk); applyStimulus(4'h0, 0, 0, 0, 0);
        checkOutput("single_valid_at_capture", o_valid, 0);
        checkOutput("single_count", o_count, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("single_valid", o_valid, 1);
            checkOutput("single_data", o_data, (k == 0) ? 256 : 0);
            checkOutput("single_idx", o_idx, k);
            checkOutput("single_last", o_last, k == 3);
        end
        @(negedge clk);
        checkOutput("single_valid_end", o_valid, 0);
        checkOutput("single_count_end", o_count, 0);
    endtask

    task automatic testSat();
        int expSat [4] = '{511, 511, 511, 128};
        i_ready = 1'b1;
        @(negedge clk); applyStimulus(4'hF, 600, 511, 512, 128);
        @(negedge clk); applyStimulus(4'h0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("sat_data", o_data, expSat[k]);
        end
        @(negedge clk);
        checkOutput("sat_valid_end", o_valid, 0);
    endtask

    task automatic testBackpressure();
        i_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (j >= 2) begin
                checkOutput("bp_hold_valid", o_valid, 1);
                checkOutput("bp_hold_data", o_data, 1);
            end
            applyStimulus(4'hF, j * 16 + 1, j * 16 + 2, j * 16 + 3, j * 16 + 4);
        end
        @(negedge clk); applyStimulus(4'h0, 0, 0, 0, 0);
        checkOutput("bp_count_full", o_count, 4);
        checkOutput("bp_drop", o_drop_cnt, 2);
        repeat (2) begin
            @(negedge clk);
            checkOutput("bp_stall_valid", o_valid, 1);
            checkOutput("bp_stall_data", o_data, 1);
            checkOutput("bp_stall_idx", o_idx, 0);
        end
        i_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checkOutput("bp_beat_valid", o_valid, 1);
            checkOutput("bp_beat_data", o_data, (k / 4) * 16 + (k % 4) + 1);
            checkOutput("bp_beat_idx", o_idx, k % 4);
            @(negedge clk);
        end
        checkOutput("bp_valid_end", o_valid, 0);
        checkOutput("bp_count_end", o_count, 0);
    endtask

    task automatic testPushPopFull();
        i_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            applyStimulus(4'hF, 300 + j * 4, 301 + j * 4, 302 + j * 4, 303 + j * 4);
        end
        @(negedge clk); applyStimulus(4'h0, 0, 0, 0, 0);
        i_ready = 1'b1;
        checkOutput("ppf_count_full", o_count, 4);
        repeat (3) @(negedge clk);
        checkOutput("ppf_idx3", o_idx, 3);
        applyStimulus(4'hF, 77, 600, 88, 99);
        @(negedge clk); applyStimulus(4'h0, 0, 0, 0, 0);
        checkOutput("ppf_count", o_count, 4);
        checkOutput("ppf_drop", o_drop_cnt, 2);
        checkOutput("ppf_next_head", o_data, 304);
        waitDrain(100);
    endtask

    task automatic testMisalign();
        i_ready = 1'b1;
        @(negedge clk); applyStimulus(4'b0101, 5, 6, 7, 8);
        @(negedge clk); applyStimulus(4'h0, 0, 0, 0, 0);
        checkOutput("mis_err", o_err_misalign, 1);
        checkOutput("mis_count", o_count, 0);
        @(negedge clk);
        checkOutput("mis_no_output", o_valid, 0);
        applyStimulus(4'hF, 1, 2, 3, 4);
        @(negedge clk); applyStimulus(4'h0, 0, 0, 0, 0);
        waitDrain(50);
        checkOutput("mis_err_sticky", o_err_misalign, 1);
        checkOutput("mis_drop_unchanged", o_drop_cnt, 2);
    endtask

    task automatic testResetMid();
        i_ready = 1'b1;
        @(negedge clk); applyStimulus(4'hF, 40, 41, 42, 43);
        @(negedge clk); applyStimulus(4'h0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checkOutput("rm_two_beats_done", o_idx, 2);
        #2 rst = 1'b0;
        #1;
        checkOutput("rm_valid", o_valid, 0);
        checkOutput("rm_count", o_count, 0);
        checkOutput("rm_idx", o_idx, 0);
        checkOutput("rm_last", o_last, 0);
        checkOutput("rm_data", o_data, 0);
        checkOutput("rm_err_cleared", o_err_misalign, 0);
        checkOutput("rm_drop_cleared", o_drop_cnt, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk); applyStimulus(4'hF, 50, 51, 52, 53);
        @(negedge clk); applyStimulus(4'h0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rm_new_valid", o_valid, 1);
        checkOutput("rm_new_idx", o_idx, 0);
        checkOutput("rm_new_data", o_data, 50);
        waitDrain(50);
    endtask

    task automatic testRandom();
        logic [3:0] mask;
        int r;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            i_ready = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 19));
            if (r < 8) mask = 4'hF;
            else if (r == 8) mask = 4'($urandom_range(1, 14));
            else mask = 4'h0;
            applyStimulus(mask, randQ(), randQ(), randQ(), randQ());
        end
        @(negedge clk); applyStimulus(4'h0, 0, 0, 0, 0);
        waitDrain(200);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", o_valid, 0);
        checkOutput("reset_idx", o_idx, 0);
        checkOutput("reset_last", o_last, 0);
        checkOutput("reset_data", o_data, 0);
        checkOutput("reset_count", o_count, 0);
        checkOutput("reset_drop", o_drop_cnt, 0);
        checkOutput("reset_err", o_err_misalign, 0);
        #2 rst = 1'b1;
        testSingle();
        testSat();
        testBackpressure();
        testPushPopFull();
        testMisalign();
        testResetMid();
        testRandom();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/norm_result_packer.md
Name: norm_result_packer

Overview:
- Downstream consumer of the four-lane vector-normalisation pipeline. It takes the four per-lane quotient outputs, each with its own valid.
- Checks that the four valids are aligned, then saturates each quotient to a narrow result width and buffers whole vectors in a small FIFO.
- Drains the FIFO as a serial element stream using a valid/ready handshake, one element per beat.
- Provides the buffering and back-pressure boundary that the free-running normaliser lacks. Lost vectors and lane misalignment are reported through status outputs.

Parameters:
- DATAWIDTH, 8: input element width of the normaliser; quotient inputs are QW = 2*DATAWIDTH+2 bits.
- FRAC_BITS, 8: fractional bits in the quotient; 1.0 = 2^FRAC_BITS.
- OUT_WIDTH, FRAC_BITS+1: width of each emitted element, unsigned, same binary point as the input.
- DEPTH, 4: FIFO depth in whole vectors; must be a power of 2 and ≥ 2.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- i_valid_A, i_valid_B, i_valid_C, i_valid_D, input, 1 each: per-lane quotient valid.
- i_q_A, i_q_B, i_q_C, i_q_D, input, QW each: per-lane quotient (fixed point, FRAC_BITS fractional bits).
- o_valid, output, 1: output element valid.
- i_ready, input, 1: downstream ready.
- o_data, output, OUT_WIDTH: current element.
- o_idx, output, 2: lane index of o_data (0=A, 1=B, 2=C, 3=D).
- o_last, output, 1: high when o_idx==3.
- o_count, output, $clog2(DEPTH+1): number of vectors held in the FIFO.
- o_drop_cnt, output, 16: dropped-vector counter; saturates at 16'hFFFF.
- o_err_misalign, output, 1: sticky lane-misalignment error.

Behaviour:
- Reset (rst==0, asynchronous):
  - FIFO pointers, o_count, element index, o_drop_cnt and o_err_misalign are cleared.
  - o_valid=0, o_idx=0, o_last=0. o_data is don't-care but must be driven to 0.
  - A reset mid-stream discards all buffered vectors and any partially sent vector.
- Capture:
  - A vector is presented when all four i_valid_* are high in the same cycle.
  - Each lane is saturated: sat(q) = q if q < 2^OUT_WIDTH, else 2^OUT_WIDTH-1. This is a plain truncation of upper bits with saturation; there is no rounding.
  - The four saturated elements are written as one FIFO entry at that clock edge.
- Misalignment:
  - Triggered when any i_valid_* is high but not all four are high.
  - Nothing is written, o_err_misalign is set to 1 and stays set until reset.
  - o_drop_cnt is unchanged.
- FIFO full:
  - A presented vector is accepted if count < DEPTH, or if the head vector's final element (idx 3) completes a handshake in the same cycle (pop and push together).
  - Otherwise the vector is dropped and o_drop_cnt increments, saturating at 16'hFFFF.
- o_count next value:
  - +1 on push only, -1 on pop only, unchanged on push+pop.
  - Never exceeds DEPTH and never underflows.
- Serializer, two states:
  - IDLE: o_valid=0. Moves to SEND on the cycle after o_count becomes nonzero. Capture-to-first-o_valid latency is 1 cycle.
  - SEND: o_valid=1, o_data = head element[idx], o_idx = idx.
  - On o_valid & i_ready, idx advances.
  - When idx==3 completes: the head is popped and idx returns to 0. The state stays in SEND if another vector remains (no bubble between vectors), else goes to IDLE.
- Output stability: while o_valid=1 and i_ready=0, o_data, o_idx and o_last hold stable. o_valid never drops without a handshake, except on reset.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Full and empty are distinguished by o_count, not by pointer equality.
- Throughput: a steady-state stream of 4 beats per vector. Sustained input faster than one vector per 4 cycles eventually fills the FIFO and drops vectors.

Test Plan:
- Single vector: q=(256,0,0,0) with FRAC_BITS=8, OUT_WIDTH=9, i_ready=1.
  - Required: o_valid rises 1 cycle after capture.
  - Beats: (256,idx0), (0,1), (0,2), (0,3,last=1), then o_valid=0 and o_count returns to 0.
- Saturation: q=(600,511,512,128).
  - Required: emitted 511, 511, 511, 128.
- Back-pressure:
  - Stimulus: i_ready=0 while DEPTH+2=6 vectors are pushed.
  - Required: o_count=4, o_drop_cnt=2, o_valid=1 and o_data stable throughout.
  - Then release i_ready: 16 beats in push order with no gap, and the correct vectors are dropped.
- Push with pop on full:
  - Stimulus: FIFO full, with a new vector presented on the same cycle the idx-3 handshake occurs.
  - Required: the vector is accepted, o_count stays 4, o_drop_cnt is unchanged.
- Misalignment:
  - Stimulus: only i_valid_A and i_valid_C are high for one cycle.
  - Required: no write, o_err_misalign=1 and stays high through later good vectors; reset clears it.
- Reset mid-stream:
  - Stimulus: assert rst low asynchronously mid-cycle after 2 beats of a vector.
  - Required: o_valid=0 immediately, o_count=0. After release, a new vector starts at idx 0.
